div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divider executing DIV, DIVU, REM and REMU on 32-bit operands. It uses a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the ALU in the execute stage. The control unit starts it with a one-cycle `start` pulse and stalls the pipeline while `busy` is high. Division-by-zero and signed-overflow results follow the RISC-V M-extension definition, so no trap is raised.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk`.
- `start`  in  1  request pulse; accepted only when `busy`=0.
- `op`  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`.
- `dividend`  in  XLEN  rs1 value; sampled with `start`.
- `divisor`  in  XLEN  rs2 value; sampled with `start`.
- `busy`  out  1  high while an accepted operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  quotient for DIV/DIVU, remainder for REM/REMU; holds its value until the next accepted `start`.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: 32 restoring iterations.
  - FIX: sign correction and result select.
  - DONE: `done`=1.
- IDLE/DONE + `start` moves to CALC, or straight to DONE for a special case. DONE without `start` moves to IDLE. CALC moves to FIX after its 32nd iteration. FIX always moves to DONE.
- `busy` = 1 in CALC and FIX. `busy` = 0 in IDLE and DONE, so a new `start` is accepted in the DONE cycle.
- `start` while `busy`=1 is ignored, and the in-flight operation is unaffected.
- Signed ops (DIV/REM):
  - Operands are converted to magnitudes at accept time.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Unsigned ops skip both conversions.
- Iteration step:
  - {rem, quo} is shifted left by 1.
  - A 33-bit trial subtract rem − divisor is computed.
  - If the difference is non-negative, rem is replaced by the difference and quo[0]=1; otherwise rem is restored and quo[0]=0.
  - The iteration counter runs 0..31.
- Special cases are detected at accept time and go directly to DONE:
  - divisor = 0: quotient = 0xFFFFFFFF (all ops); remainder = dividend.
  - DIV/REM with dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Reset mid-operation abandons the calculation. The state returns to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- Normal latency: let edge E0 be the one that accepts `start`. Iterations occur on E1..E32, FIX on E33, and `done` is high in the cycle following E33. The total is 34 clocks from start edge to `done`.
- Special-case latency: `done` is high in the cycle following E0 (1 clock).
- A new `start` in the DONE cycle gives back-to-back operation. `done` drops on the next edge and `busy` rises.
- `result` changes only on the edge entering DONE.

## Structure
- Shared package `rv32m_pkg`:
  - op encoding constants `OP_DIV`, `OP_DIVU`, `OP_REM`, `OP_REMU`.
  - state typedef `div_state_t` (IDLE, CALC, FIX, DONE).
  - `XLEN` constant.
- Sub-module `div_step`: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - The 33-bit trial subtract is built as an adder with an inverted divisor and carry-in = 1.
- Top level holds the FSM, the 5-bit counter, sign flags, operand registers and the result register.

## Test plan
- DIVU 100/7 → `result`=14 with `done` exactly 34 clocks after start. REMU 100/7 → 2.
- DIV 0xFFFFFFF9(−7)/2 → 0xFFFFFFFD(−3). REM same operands → 0xFFFFFFFF(−1). REM 7/0xFFFFFFFE → 1.
- DIVU 5/0 → 0xFFFFFFFF with `done` 1 clock after start. REMU 5/0 → 5. DIV 0x80000000/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. Both with 1-clock latency.
- Second `start` (DIVU 9/3) at clock 10 of a DIVU 100/7 → ignored, and `result`=14. Then `start` DIVU 9/3 issued in the `done` cycle → 3 after 34 clocks.
- `rst_n`=0 at clock 15 of an operation → `busy`=0, `done`=0 and `result`=0 after the edge; no `done` appears afterwards. A new DIVU 100/7 → 14.

Source files
------------

// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared RV32M constants, op encoding and divider state type
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct read as unsigned.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between control unit and divider
interface div_unit_if;
    import rv32m_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, output op, output dividend, output divisor,
                    input busy, input done, input result);
    modport slave  (input start, input op, input dividend, input divisor,
                    output busy, output done, output result);
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
    import rv32m_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;
    logic          fits;

    assign rem_sh = {rem, quo[XLEN-1]};
    // Subtract as add of inverted divisor with carry-in; bit XLEN is the sign of the difference.
    assign trial  = rem_sh + {1'b1, ~divisor} + {{XLEN{1'b0}}, 1'b1};
    assign fits   = ~trial[XLEN];

    assign rem_nxt = fits ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock
module div_unit
    import rv32m_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);

    div_state_t      state, state_nxt;
    logic [4:0]      cnt;
    logic [XLEN-1:0] rem, quo, dvsr, result_q;
    logic [XLEN-1:0] step_rem, step_quo, special_res;
    logic            neg_q, neg_r, is_rem;
    logic            busy, is_signed, div_zero, sgn_ovf, special;

    assign busy      = (state == CALC) || (state == FIX);
    assign is_signed = ~bus.op[0];
    assign div_zero  = (bus.divisor == '0);
    assign sgn_ovf   = is_signed && (bus.dividend == 32'h8000_0000) && (bus.divisor == '1);
    assign special   = div_zero || sgn_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = bus.op[1] ? bus.dividend : '1;
        else
            special_res = bus.op[1] ? '0 : 32'h8000_0000;
    end

    div_step u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvsr),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = bus.start ? (special ? DONE : CALC) : IDLE;
            CALC:       if (cnt == 5'd31) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (special) begin
                            result_q <= special_res;
                        end else begin
                            rem    <= '0;
                            quo    <= is_signed ? abs_val(bus.dividend) : bus.dividend;
                            dvsr   <= is_signed ? abs_val(bus.divisor)  : bus.divisor;
                            neg_q  <= is_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                            neg_r  <= is_signed && bus.dividend[XLEN-1];
                            is_rem <= bus.op[1];
                            cnt    <= '0;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    if (is_rem) result_q <= neg_r ? (~rem + 1'b1) : rem;
                    else        result_q <= neg_q ? (~quo + 1'b1) : quo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random checks of div_unit against an arithmetic reference
module tb_div_unit;
    import rv32m_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    div_unit_if ifc ();

    div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues an op (possibly in a DONE cycle) and leaves the bench in the resulting DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          el;
        logic [31:0] er;
        er = ref_model(o, a, b);
        el = ref_lat(o, a, b);
        ifc.start = 1'b1; ifc.op = o; ifc.dividend = a; ifc.divisor = b;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        lat = 1;
        if (el > 1) begin
            chk({tag, "/busy"}, 32'(ifc.busy), 32'd1);
            chk({tag, "/nodone"}, 32'(ifc.done), 32'd0);
        end
        while (ifc.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/done"}, 32'(ifc.done), 32'd1);
        chk({tag, "/res"}, ifc.result, er);
        chk({tag, "/lat"}, 32'(lat), 32'(el));
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [1:0]  o;
        logic [31:0] a, b;

        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.op = 2'b00; ifc.dividend = '0; ifc.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/busy", 32'(ifc.busy), 32'd0);
        chk("rst/done", 32'(ifc.done), 32'd0);
        chk("rst/res", ifc.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0);
        run_op("div_min_0", OP_DIV, 32'h8000_0000, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk); #1;

        // A start while busy must not disturb the running DIVU 100/7.
        ifc.start = 1'b1; ifc.op = OP_DIVU; ifc.dividend = 32'd100; ifc.divisor = 32'd7;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        lat = 1;
        while (ifc.done !== 1'b1 && lat < 100) begin
            if (lat == 10) begin
                ifc.start = 1'b1; ifc.op = OP_DIVU; ifc.dividend = 32'd9; ifc.divisor = 32'd3;
            end else begin
                ifc.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        ifc.start = 1'b0;
        chk("ign/res", ifc.result, 32'd14);
        chk("ign/lat", 32'(lat), 32'd34);
        run_op("b2b_9_3", OP_DIVU, 32'd9, 32'd3);

        // Reset partway through abandons the operation.
        ifc.start = 1'b1; ifc.op = OP_DIVU; ifc.dividend = 32'd100; ifc.divisor = 32'd7;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst/busy", 32'(ifc.busy), 32'd0);
        chk("mrst/done", 32'(ifc.done), 32'd0);
        chk("mrst/res", ifc.result, 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ifc.done === 1'b1) ndone++;
        end
        chk("mrst/nodone", 32'(ndone), 32'd0);
        run_op("after_rst", OP_DIVU, 32'd100, 32'd7);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = 32'd0;
                3:       b = 32'd0 - 32'($urandom_range(1, 300));
                default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            endcase
            run_op($sformatf("rnd%0d", i), o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
